// File: rtl/timeslice_rr_arbiter.sv
// -----------------------------------------------------------------------------
// timeslice_rr_arbiter
//
// Round-robin arbiter that grants the shared resource for a time slice of
// k cycles.  The slice length is sampled from i_k when a grant starts.  A
// slice ends early when the grantee drops its request.  At every slice end
// the next requester in round-robin order is granted on the same edge, so no
// idle cycle appears between grants.
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset
//   i_k          slice length in cycles (0 behaves as 1), sampled at grant start
//   i_req        request vector, bit i belongs to requester i
//   o_grant      one-hot grant, all-zero when idle (registered)
//   o_busy       high whenever o_grant is non-zero (registered)
//   o_slice_end  high during the final cycle of a slice (registered)
// -----------------------------------------------------------------------------
module timeslice_rr_arbiter #(
   parameter int N = 4,
   parameter int W = 3
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [W-1:0] i_k,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant,
   output logic         o_busy,
   output logic         o_slice_end
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   cnt;
   logic [W-1:0]   cnt_nxt;
   logic [W-1:0]   k_lat;
   logic [W-1:0]   k_lat_nxt;
   logic [LW-1:0]  last;
   logic [LW-1:0]  last_nxt;
   logic [LW-1:0]  winner;
   logic           found;
   logic           holder_req;
   logic           slice_over;
   logic           take_new;
   logic [N-1:0]   grant_nxt;

   // Round-robin search: start just after the most recent grantee and wrap
   // around so that the most recent grantee itself is the last candidate.
   always_comb begin : winner_search
      int idx;
      winner = last;
      found  = 1'b0;
      idx    = 0;
      for (int off = 1; off <= N; off++) begin
         idx = int'(last) + off;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && i_req[idx]) begin
            winner = LW'(idx);
            found  = 1'b1;
         end
      end
   end

   // The registered one-hot grant identifies the current holder, so masking
   // the request vector with it tells whether the holder still wants the
   // resource.  A dropped request ends the slice regardless of the counter.
   // In IDLE the grant is zero, so a new arbitration is always allowed.
   always_comb begin
      holder_req = |(i_req & o_grant);
      slice_over = !holder_req || (cnt == (k_lat - W'(1)));
      take_new   = (state == IDLE) || slice_over;

      state_nxt  = state;
      grant_nxt  = o_grant;
      cnt_nxt    = cnt + W'(1);
      k_lat_nxt  = k_lat;
      last_nxt   = last;

      if (take_new) begin
         cnt_nxt = '0;
         if (found) begin
            state_nxt = GRANT;
            grant_nxt = {{(N-1){1'b0}}, 1'b1} << winner;
            k_lat_nxt = (i_k == '0) ? W'(1) : i_k;
            last_nxt  = winner;
         end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      end
   end

   // All outputs are registered.  o_slice_end is raised on the edge that
   // enters the final cycle of a slice, so it is high throughout that cycle.
   // Entering that cycle implies the holder was still requesting at the edge.
   // A one-cycle slice enters its final cycle at the granting edge itself.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         cnt         <= '0;
         k_lat       <= W'(1);
         last        <= LW'(N - 1);
         o_grant     <= '0;
         o_busy      <= 1'b0;
         o_slice_end <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         k_lat       <= k_lat_nxt;
         last        <= last_nxt;
         o_grant     <= grant_nxt;
         o_busy      <= |grant_nxt;
         o_slice_end <= (state_nxt == GRANT) && (cnt_nxt == (k_lat_nxt - W'(1)));
      end
   end

endmodule

// File: tb/tb_timeslice_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timeslice_rr_arbiter
//
// Scoreboard bench for timeslice_rr_arbiter (N=4, W=3).  The driver applies one
// input vector per clock.  For each vector, a countdown-based reference model
// predicts the outputs after the next edge, and the prediction is pushed into
// a queue.  A separate monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_timeslice_rr_arbiter;

   localparam int N = 4;
   localparam int W = 3;

   logic         i_clk;
   logic         i_reset;
   logic [W-1:0] i_k;
   logic [N-1:0] i_req;
   logic [N-1:0] o_grant;
   logic         o_busy;
   logic         o_slice_end;

   int total;
   int bad;
   int cycle;

   // Expected {grant, busy, slice_end} for each upcoming edge, in order.
   logic [N+1:0] expQ[$];

   // Reference model state: owner of the resource (-1 when idle), cycles left
   // in the current slice including the present one, and the last grantee.
   int mOwner;
   int mLeft;
   int mLast;

   timeslice_rr_arbiter #(.N(N), .W(W)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_k         (i_k),
      .i_req       (i_req),
      .o_grant     (o_grant),
      .o_busy      (o_busy),
      .o_slice_end (o_slice_end)
   );

   // Free-running clock, period 10.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Advance the reference model by one clock edge and return its outputs.
   task automatic modelStep(input logic r, input logic [N-1:0] req,
                            input logic [W-1:0] k, output logic [N+1:0] e);
      logic [N-1:0] g;
      bit ending;
      int w;
      if (r) begin
         mOwner = -1;
         mLeft  = 0;
         mLast  = N - 1;
      end else begin
         ending = (mOwner < 0) || !req[mOwner] || (mLeft == 1);
         if (ending) begin
            w = -1;
            for (int off = 1; off <= N; off++) begin
               if (w < 0 && req[(mLast + off) % N]) begin
                  w = (mLast + off) % N;
               end
            end
            mOwner = w;
            if (w >= 0) begin
               mLeft = (k == 0) ? 1 : int'(k);
               mLast = w;
            end
         end else begin
            mLeft = mLeft - 1;
         end
      end
      g = '0;
      if (mOwner >= 0) begin
         g[mOwner] = 1'b1;
      end
      e = {g, (mOwner >= 0), (mOwner >= 0) && (mLeft == 1)};
   endtask

   // Drive one vector, record its predicted effect, then wait for the edge.
   task automatic applyStimulus(input logic r, input logic [N-1:0] req,
                                input logic [W-1:0] k);
      logic [N+1:0] e;
      i_reset = r;
      i_req   = req;
      i_k     = k;
      modelStep(r, req, k, e);
      expQ.push_back(e);
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input logic [N+1:0] e);
      logic [N+1:0] got;
      got   = {o_grant, o_busy, o_slice_end};
      total = total + 1;
      if (got !== e) begin
         bad = bad + 1;
         $display("[TB] FAIL cycle%0d grant/busy/slice_end got=%b_%b_%b want=%b_%b_%b",
                  cycle, got[N+1:2], got[1], got[0], e[N+1:2], e[1], e[0]);
      end
   endtask

   // Monitor: the outputs settle after the rising edge and are compared on
   // the falling edge against the oldest pending prediction.
   initial begin
      forever begin
         @(negedge i_clk);
         if (expQ.size() > 0) begin
            cycle = cycle + 1;
            checkOutput(expQ.pop_front());
         end
      end
   end

   initial begin
      logic [N-1:0] rq;
      total  = 0;
      bad    = 0;
      cycle  = 0;
      mOwner = -1;
      mLeft  = 0;
      mLast  = N - 1;
      i_reset = 1'b1;
      i_req   = '0;
      i_k     = '0;

      // Reset held with everyone requesting, then the first grant goes to 0.
      applyStimulus(1'b1, 4'b1111, 3'd4);
      applyStimulus(1'b1, 4'b1111, 3'd4);
      applyStimulus(1'b0, 4'b1111, 3'd4);
      applyStimulus(1'b0, 4'b0000, 3'd4);
      applyStimulus(1'b0, 4'b0000, 3'd4);

      // Sole requester, slices of 4 back to back.
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 4'b0001, 3'd4);
      applyStimulus(1'b0, 4'b0000, 3'd4);

      // Full rotation with everyone requesting.
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'b1111, 3'd4);

      // Early release by requester 0 during its second cycle.
      applyStimulus(1'b1, 4'b0000, 3'd3);
      applyStimulus(1'b0, 4'b0101, 3'd3);
      applyStimulus(1'b0, 4'b0101, 3'd3);
      applyStimulus(1'b0, 4'b0100, 3'd3);
      applyStimulus(1'b0, 4'b0100, 3'd3);
      applyStimulus(1'b0, 4'b0100, 3'd3);

      // Slice length changes mid-slice, then zero-length slices.
      applyStimulus(1'b1, 4'b0000, 3'd4);
      applyStimulus(1'b0, 4'b0011, 3'd4);
      applyStimulus(1'b0, 4'b0011, 3'd2);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b0011, 3'd2);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b0011, 3'd0);

      // Reset in the middle of a grant to requester 2, then re-arbitrate.
      applyStimulus(1'b1, 4'b0000, 3'd4);
      applyStimulus(1'b0, 4'b0100, 3'd4);
      applyStimulus(1'b0, 4'b0100, 3'd4);
      applyStimulus(1'b0, 4'b0100, 3'd4);
      applyStimulus(1'b1, 4'b0100, 3'd4);
      applyStimulus(1'b0, 4'b0111, 3'd4);
      applyStimulus(1'b0, 4'b0111, 3'd4);

      // Randomized traffic: requests change occasionally, slice lengths vary.
      rq = 4'b1010;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rq = 4'($urandom_range(0, 15));
         end
         applyStimulus(($urandom_range(0, 79) == 0), rq, 3'($urandom_range(0, 7)));
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
         @(negedge i_clk);
         #1;
      end
      if (expQ.size() > 0) begin
         total = total + 1;
         bad   = bad + 1;
         $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
